// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch (read-only) and data (read/write) ports onto one multi-cycle memory.
// Latency is LATENCY+1 cycles to done. Requests are held until done. Optional MEMARB_RR_EN selects round-robin arbitration.
module mem_port_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  input  logic          halt,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_dump,
  output logic          busy
);

  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count;
  logic          owner;  // 1 = data port owns the current access
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] if_rdata_q, dm_rdata_q;
  logic          grant, pick_dm, last_cnt;

`ifdef MEMARB_RR_EN
  logic last_owner;

  // On conflict, the port that lost the previous grant goes first.
  assign pick_dm = dm_req & (~if_req | ~last_owner);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       last_owner <= 1'b0;
    else if (grant) last_owner <= pick_dm;
  end
`else
  assign pick_dm = dm_req;
`endif

  assign grant    = (state == IDLE) & ~halt & (if_req | dm_req);
  assign last_cnt = (count == CW'(LATENCY - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  if (last_cnt) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == ACCESS && !last_cnt) count <= count + CW'(1);
      else                              count <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner   <= pick_dm;
      wr_q    <= pick_dm & dm_wr;
      addr_q  <= pick_dm ? dm_addr : if_addr;
      wdata_q <= pick_dm ? dm_wdata : '0;
    end
  end

  // Read data is sampled on the final cycle the memory is held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else if (state == ACCESS && last_cnt && !wr_q) begin
      if (owner) dm_rdata_q <= mem_rdata;
      else       if_rdata_q <= mem_rdata;
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_wr    = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_done   = (state == RESP) & ~owner;
  assign dm_done   = (state == RESP) & owner;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state != IDLE);
  // Gated by reset so the dump request is also forced low while in reset.
  assign mem_dump  = halt & (state == IDLE) & rst;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory model plus transaction-level schedule model.
module tb_mem_port_arbiter;
  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_wr = 1'b0, halt = 1'b0;
  logic [15:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, dm_done, mem_en, mem_wr, mem_dump, busy;

  logic        if_req1 = 1'b0, dm_req1 = 1'b0, dm_wr1 = 1'b0, halt1 = 1'b0;
  logic [15:0] if_addr1 = '0, dm_addr1 = '0, dm_wdata1 = '0;
  logic [15:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
  logic        if_done1, dm_done1, mem_en1, mem_wr1, mem_dump1, busy1;

  logic [15:0] mem [256];
  logic [15:0] shadow [256];
  int total = 0;
  int bad = 0;
  bit last_dm = 1'b0;

  always #5 clk = ~clk;

  assign mem_rdata  = mem[mem_addr[7:0]];
  assign mem_rdata1 = mem[mem_addr1[7:0]];

  mem_port_arbiter #(.LATENCY(L), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .halt(halt),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_dump(mem_dump), .busy(busy)
  );

  mem_port_arbiter #(.LATENCY(1), .AW(16), .DW(16)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1), .if_done(if_done1),
    .dm_req(dm_req1), .dm_wr(dm_wr1), .dm_addr(dm_addr1), .dm_wdata(dm_wdata1),
    .dm_rdata(dm_rdata1), .dm_done(dm_done1), .halt(halt1),
    .mem_en(mem_en1), .mem_wr(mem_wr1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .mem_dump(mem_dump1), .busy(busy1)
  );

  // Runs up to two requests raised together; the expected schedule is derived from
  // the arbitration rule and the LATENCY+2 cycle access period.
  task automatic run_pair(input bit ifr, input bit dmr, input bit dmw,
                          input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
    int n;
    bit own[2];
    int start[2];
    int last;
    bit e_en, e_wr, e_ifd, e_dmd, e_busy;
    logic [15:0] e_addr;
    n = 0; own[0] = 1'b0; own[1] = 1'b0;
    if (ifr && dmr) begin
`ifdef MEMARB_RR_EN
      own[0] = !last_dm;
`else
      own[0] = 1'b1;
`endif
      own[1] = !own[0];
      n = 2;
    end else if (dmr) begin
      own[0] = 1'b1; n = 1;
    end else if (ifr) begin
      own[0] = 1'b0; n = 1;
    end
    start[0] = 1;
    start[1] = L + 3;
    last = (n == 0) ? 3 : start[n-1] + L + 1;
    if_req = ifr; if_addr = ia;
    dm_req = dmr; dm_wr = dmw; dm_addr = da; dm_wdata = wd;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      e_en = 0; e_wr = 0; e_ifd = 0; e_dmd = 0; e_busy = 0; e_addr = '0;
      for (int j = 0; j < n; j++) begin
        if (k >= start[j] && k < start[j] + L) begin
          e_en = 1; e_busy = 1; e_wr = own[j] && dmw; e_addr = own[j] ? da : ia;
        end
        if (k == start[j] + L) begin
          e_busy = 1;
          if (own[j]) e_dmd = 1; else e_ifd = 1;
        end
      end
      if (mem_en && mem_wr) mem[mem_addr[7:0]] = mem_wdata;
      total++; if (mem_en !== e_en) begin bad++; $display("FAIL mem_en k=%0d got=%b exp=%b", k, mem_en, e_en); end
      total++; if (mem_wr !== e_wr) begin bad++; $display("FAIL mem_wr k=%0d got=%b exp=%b", k, mem_wr, e_wr); end
      total++; if (if_done !== e_ifd) begin bad++; $display("FAIL if_done k=%0d got=%b exp=%b", k, if_done, e_ifd); end
      total++; if (dm_done !== e_dmd) begin bad++; $display("FAIL dm_done k=%0d got=%b exp=%b", k, dm_done, e_dmd); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL busy k=%0d got=%b exp=%b", k, busy, e_busy); end
      total++; if (mem_dump !== 1'b0) begin bad++; $display("FAIL mem_dump k=%0d got=%b exp=0", k, mem_dump); end
      if (e_en) begin
        total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL mem_addr k=%0d got=%h exp=%h", k, mem_addr, e_addr); end
      end
      if (e_wr) begin
        total++; if (mem_wdata !== wd) begin bad++; $display("FAIL mem_wdata k=%0d got=%h exp=%h", k, mem_wdata, wd); end
      end
      if (e_ifd) begin
        total++; if (if_rdata !== shadow[ia[7:0]]) begin bad++; $display("FAIL if_rdata k=%0d got=%h exp=%h", k, if_rdata, shadow[ia[7:0]]); end
      end
      if (e_dmd) begin
        if (dmw) shadow[da[7:0]] = wd;
        else begin
          total++; if (dm_rdata !== shadow[da[7:0]]) begin bad++; $display("FAIL dm_rdata k=%0d got=%h exp=%h", k, dm_rdata, shadow[da[7:0]]); end
        end
      end
      @(posedge clk); #1;
      if (e_ifd) if_req = 1'b0;
      if (e_dmd) dm_req = 1'b0;
    end
    if_req = 1'b0; dm_req = 1'b0;
    if (n > 0) last_dm = own[n-1];
  endtask

  task automatic test_reset();
    rst = 1'b0; halt = 1'b1;
    #2;
    total++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, busy, mem_en1, dm_done1} !== '0) begin
      bad++; $display("FAIL reset_outputs got=%b/%b/%h/%h exp=0", mem_en, busy, mem_addr, dm_rdata);
    end
    total++; if (mem_dump !== 1'b0) begin bad++; $display("FAIL reset_dump got=%b exp=0", mem_dump); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; halt = 1'b0; last_dm = 1'b0;
  endtask

  task automatic test_fetch_read();
    mem[8'h10] = 16'hBEEF; shadow[8'h10] = 16'hBEEF;
    run_pair(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h0000);
  endtask

  task automatic test_write_read();
    run_pair(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0020, 16'h1234);
    run_pair(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0020, 16'h0000);
  endtask

  task automatic test_conflict();
    run_pair(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0022, 16'h0000);
    run_pair(1'b1, 1'b1, 1'b1, 16'h0033, 16'h0033, 16'hA5C3);
  endtask

  task automatic test_halt();
    bit e_en, e_dmd, e_dump, e_busy;
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0030;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      e_en   = (k >= 1 && k <= L);
      e_dmd  = (k == L + 1);
      e_busy = (k >= 1 && k <= L + 1);
      e_dump = halt && (k > L + 1);
      total++; if (mem_en !== e_en) begin bad++; $display("FAIL halt_mem_en k=%0d got=%b exp=%b", k, mem_en, e_en); end
      total++; if (dm_done !== e_dmd) begin bad++; $display("FAIL halt_dm_done k=%0d got=%b exp=%b", k, dm_done, e_dmd); end
      total++; if (if_done !== 1'b0) begin bad++; $display("FAIL halt_if_done k=%0d got=%b exp=0", k, if_done); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL halt_busy k=%0d got=%b exp=%b", k, busy, e_busy); end
      total++; if (mem_dump !== e_dump) begin bad++; $display("FAIL halt_dump k=%0d got=%b exp=%b", k, mem_dump, e_dump); end
      if (e_dmd) begin
        total++; if (dm_rdata !== shadow[8'h30]) begin bad++; $display("FAIL halt_dm_rdata got=%h exp=%h", dm_rdata, shadow[8'h30]); end
      end
      @(posedge clk); #1;
      if (k == 1) begin halt = 1'b1; if_req = 1'b1; if_addr = 16'h0040; end
      if (k == L + 1) dm_req = 1'b0;
    end
    last_dm = 1'b1;
    halt = 1'b0;
    run_pair(1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 16'h0000);
  endtask

  task automatic test_reset_mid_access();
    dm_req = 1'b1; dm_wr = 1'b0; dm_addr = 16'h0050;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    total++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata, if_done, dm_done, if_rdata, dm_rdata, busy, mem_dump} !== '0) begin
      bad++; $display("FAIL midreset_outputs got=%b/%b/%h/%h exp=0", mem_en, busy, mem_addr, dm_rdata);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++; if (dm_done !== 1'b0) begin bad++; $display("FAIL midreset_dm_done k=%0d got=%b exp=0", k, dm_done); end
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL midreset_mem_en k=%0d got=%b exp=0", k, mem_en); end
    end
    @(posedge clk); #1;
    rst = 1'b1; last_dm = 1'b0;
    run_pair(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0050, 16'h0000);
  endtask

  task automatic test_latency1();
    logic [15:0] cur;
    bit e_en, e_dmd;
    cur = 16'($urandom_range(0, 255));
    dm_req1 = 1'b1; dm_addr1 = cur;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      e_en  = (k % 3 == 1);
      e_dmd = (k % 3 == 2);
      total++; if (mem_en1 !== e_en) begin bad++; $display("FAIL l1_mem_en k=%0d got=%b exp=%b", k, mem_en1, e_en); end
      total++; if (dm_done1 !== e_dmd) begin bad++; $display("FAIL l1_dm_done k=%0d got=%b exp=%b", k, dm_done1, e_dmd); end
      total++; if (mem_wr1 !== 1'b0) begin bad++; $display("FAIL l1_mem_wr k=%0d got=%b exp=0", k, mem_wr1); end
      if (e_en) begin
        total++; if (mem_addr1 !== cur) begin bad++; $display("FAIL l1_mem_addr k=%0d got=%h exp=%h", k, mem_addr1, cur); end
      end
      if (e_dmd) begin
        total++; if (dm_rdata1 !== shadow[cur[7:0]]) begin bad++; $display("FAIL l1_dm_rdata k=%0d got=%h exp=%h", k, dm_rdata1, shadow[cur[7:0]]); end
      end
      @(posedge clk); #1;
      if (e_dmd) begin
        cur = 16'($urandom_range(0, 255));
        dm_addr1 = cur;
      end
    end
    dm_req1 = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_pair(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)), 16'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 16'(i * 257) ^ 16'hA5A5;
      shadow[i] = mem[i];
    end
    test_reset();
    test_fetch_read();
    test_write_read();
    test_conflict();
    test_halt();
    test_reset_mid_access();
    test_latency1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
